// File: rtl/gpio_out_bank.sv
// gpio_out_bank
//
// Memory-mapped bank of N_PORTS registered output ports, WIDTH bits each.
// Each port has a register block at BASE_ADDR + p*STRIDE. Its offsets are:
//   +0  DATA  : write replaces the port value; read returns the port value.
//   +4  SET   : out |= d                     (reads as 0)
//   +8  CLR   : out &= ~d                    (reads as 0)
//   +12 TGL   : out ^= d                     (reads as 0)
//   +16 PULSE : one-shot pulse on mask d     (reads as 0)
//   +20 PLEN  : pulse length in cycles, read/write
// Every other address is ignored: hit=0 and rd_data=0.
//
// Handshake: there is no ready signal. A write is accepted in any cycle where
// we=1 and the address hits a register. Its effect is visible on IO_port and
// pulse_busy in the following cycle.
//
// Pulse state per port: IDLE when cnt==0 and RUN when cnt!=0. pulse_busy
// exposes this state. Pulsed bits stay high for exactly PLEN cycles, counted
// from the first cycle in which the write is visible.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   we           bus write strobe
//   address      bus byte address (exact match, no byte lanes)
//   bus_in       write data: [WIDTH-1:0] is used, PLEN uses [CNT_W-1:0]
//   rd_data      combinational readback, zero-extended
//   hit          combinational: address decodes to a register of this block
//   IO_port      registered pin outputs; port p is at [p*WIDTH +: WIDTH]
//   pulse_busy   registered; bit p is high while port p's pulse is running
module gpio_out_bank #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned N_PORTS    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'd8,
  parameter int unsigned STRIDE     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PLEN_RESET = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [31:0]                address,
  input  logic [31:0]                bus_in,
  output logic [31:0]                rd_data,
  output logic                       hit,
  output logic [N_PORTS*WIDTH-1:0]   IO_port,
  output logic [N_PORTS-1:0]         pulse_busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]      wdata;
  logic [CNT_W-1:0]      wlen;
  logic [N_PORTS-1:0]    hit_vec;
  logic [N_PORTS*32-1:0] rd_flat;
  logic                  unused_bus;

  assign wdata      = bus_in[WIDTH-1:0];
  assign wlen       = bus_in[CNT_W-1:0];
  assign unused_bus = ^bus_in;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    localparam logic [31:0] PBASE = BASE_ADDR + 32'(p * STRIDE);

    logic             sel_data, sel_set, sel_clr, sel_tgl, sel_pulse, sel_plen;
    logic [WIDTH-1:0] out_q, pmask_q, out_c, pmask_c;
    logic [CNT_W-1:0] cnt_q, plen_q, cnt_c, plen_c;
    logic             busy_q;
    logic             expire;
    logic [31:0]      rd;

    assign sel_data  = (address == PBASE);
    assign sel_set   = (address == PBASE + 32'd4);
    assign sel_clr   = (address == PBASE + 32'd8);
    assign sel_tgl   = (address == PBASE + 32'd12);
    assign sel_pulse = (address == PBASE + 32'd16);
    assign sel_plen  = (address == PBASE + 32'd20);

    assign hit_vec[p] = sel_data | sel_set | sel_clr | sel_tgl | sel_pulse | sel_plen;

    always_comb begin
      rd = '0;
      if (sel_data) begin
        rd[WIDTH-1:0] = out_q;
      end else if (sel_plen) begin
        rd[CNT_W-1:0] = plen_q;
      end
    end
    assign rd_flat[p*32 +: 32] = rd;

    // The counter reaches zero on this edge. The pulsed bits are cleared
    // first, so that a software op in the same cycle is applied on top of the
    // cleared value and wins on any overlapping bits.
    assign expire = (cnt_q == CNT_ONE);

    always_comb begin
      out_c   = expire ? (out_q & ~pmask_q) : out_q;
      pmask_c = expire ? '0 : pmask_q;
      cnt_c   = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : cnt_q;
      plen_c  = plen_q;
      if (we) begin
        if (sel_data) begin
          out_c = wdata;
        end else if (sel_set) begin
          out_c = out_c | wdata;
        end else if (sel_clr) begin
          out_c = out_c & ~wdata;
        end else if (sel_tgl) begin
          out_c = out_c ^ wdata;
        end else if (sel_pulse) begin
          // PLEN==0 turns PULSE writes into no-ops. Retriggering while
          // running reloads the counter and merges the masks.
          if (plen_q != CNT_ZERO) begin
            out_c   = out_c | wdata;
            pmask_c = pmask_c | wdata;
            cnt_c   = plen_q;
          end
        end else if (sel_plen) begin
          plen_c = wlen;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        out_q   <= '0;
        pmask_q <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        plen_q  <= CNT_W'(PLEN_RESET);
      end else begin
        out_q   <= out_c;
        pmask_q <= pmask_c;
        cnt_q   <= cnt_c;
        busy_q  <= (cnt_c != CNT_ZERO);
        plen_q  <= plen_c;
      end
    end

    assign IO_port[p*WIDTH +: WIDTH] = out_q;
    assign pulse_busy[p]             = busy_q;
  end

  assign hit = |hit_vec;

  // At most one port decodes any given address, so OR-merging is exact.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      rd_data = rd_data | rd_flat[p*32 +: 32];
    end
  end

endmodule

// File: tb/tb_gpio_out_bank.sv
// Testbench for gpio_out_bank. It runs a directed sequence followed by a
// randomized bus traffic phase. Every cycle, all outputs are compared against
// a cycle-indexed behavioural model. The model tracks each pulse as a
// "last high cycle" deadline instead of a down-counter.
module tb_gpio_out_bank;

  localparam int unsigned W      = 16;
  localparam int unsigned N      = 2;
  localparam int unsigned BASE   = 8;
  localparam int unsigned STRIDE = 32;
  localparam int unsigned CW     = 16;
  localparam int unsigned WMASK  = (1 << W) - 1;
  localparam int unsigned CMASK  = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic            clk;
  logic            reset;
  logic            we;
  logic [31:0]     address;
  logic [31:0]     bus_in;
  logic [31:0]     rd_data;
  logic            hit;
  logic [N*W-1:0]  IO_port;
  logic [N-1:0]    pulse_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpio_out_bank #(
    .WIDTH(W), .N_PORTS(N), .BASE_ADDR(32'd8), .STRIDE(STRIDE),
    .CNT_W(CW), .PLEN_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .address(address), .bus_in(bus_in),
    .rd_data(rd_data), .hit(hit), .IO_port(IO_port), .pulse_busy(pulse_busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h time=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_out  [N];
  int unsigned m_pm   [N];
  int unsigned m_plen [N];
  int unsigned m_dl   [N];   // last cycle in which the pulsed bits are high
  bit          m_act  [N];
  int unsigned cyc;

  function automatic void model_reset();
    for (int p = 0; p < int'(N); p++) begin
      m_out[p] = 0; m_pm[p] = 0; m_plen[p] = 1; m_dl[p] = 0; m_act[p] = 0;
    end
  endfunction

  function automatic bit decode(input logic [31:0] a, output int port, output int off);
    int unsigned rel;
    port = 0; off = 0;
    if (a < BASE) return 0;
    rel  = a - BASE;
    port = int'(rel / STRIDE);
    off  = int'(rel % STRIDE);
    return (port < int'(N)) && (off <= 20) && (off % 4 == 0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int p, off;
    if (!decode(a, p, off)) return 32'h0;
    if (off == 0)  return m_out[p];
    if (off == 20) return m_plen[p];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_io();
    logic [31:0] v = '0;
    for (int p = 0; p < int'(N); p++) v = v | (m_out[p] << (p * W));
    return v;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int p = 0; p < int'(N); p++) v[p] = m_act[p];
    return v;
  endfunction

  function automatic void model_step(input bit rst, input bit w, input logic [31:0] a,
                                     input logic [31:0] d);
    int p, off;
    int unsigned dm;
    if (rst) begin
      model_reset();
    end else begin
      for (int q = 0; q < int'(N); q++) begin
        if (m_act[q] && m_dl[q] == cyc) begin
          m_out[q] = m_out[q] & ~m_pm[q];
          m_pm[q]  = 0;
          m_act[q] = 0;
        end
      end
      dm = d & WMASK;
      if (w && decode(a, p, off)) begin
        case (off)
          0:  m_out[p] = dm;
          4:  m_out[p] = m_out[p] | dm;
          8:  m_out[p] = m_out[p] & ~dm & WMASK;
          12: m_out[p] = m_out[p] ^ dm;
          16: if (m_plen[p] != 0) begin
                m_out[p] = m_out[p] | dm;
                m_pm[p]  = m_pm[p] | dm;
                m_act[p] = 1;
                m_dl[p]  = cyc + m_plen[p];
              end
          20: m_plen[p] = d & CMASK;
          default: ;
        endcase
      end
    end
    cyc++;
  endfunction

  // ---------------- driver ----------------
  // Drives one bus cycle, checks all outputs mid-cycle against the model,
  // then advances the model together with the clock edge.
  task automatic cycle(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
    reset = rst; we = w; address = a; bus_in = d;
    @(negedge clk);
    check("io",   IO_port,           model_io());
    check("busy", 32'(pulse_busy),   model_busy());
    check("hit",  32'(hit),          32'(decode_hit(a)));
    check("rd",   rd_data,           model_rd(a));
    model_step(rst, w, a, d);
    @(posedge clk);
    #1;
  endtask

  function automatic bit decode_hit(input logic [31:0] a);
    int p, off;
    return decode(a, p, off);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int unsigned addr_tab[19] = '{8, 12, 16, 20, 24, 28, 40, 44, 48, 52, 56, 60,
                                4, 200, 9, 32, 36, 64, 72};

  initial begin
    logic [31:0] a, d;
    reset = 1'b1; we = 1'b0; address = '0; bus_in = '0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    cycle(1, 0, 32'd0, 32'd0);

    // DATA write plus readback.
    cycle(0, 1, 32'd8, 32'h0000A5A5);
    check("data_io", IO_port, 32'h0000A5A5);
    address = 32'd8; we = 1'b0;
    #1;
    check("data_rd", rd_data, 32'h0000A5A5);
    check("data_hit", 32'(hit), 32'd1);

    // SET / CLR / TGL chain.
    cycle(0, 1, 32'd8, 32'h000000F0);
    cycle(0, 1, 32'd12, 32'h0000000F);
    check("set_io", IO_port, 32'h000000FF);
    cycle(0, 1, 32'd16, 32'h00000030);
    check("clr_io", IO_port, 32'h000000CF);
    cycle(0, 1, 32'd20, 32'h0000FFFF);
    check("tgl_io", IO_port, 32'h0000FF30);

    // One-shot on port 1, length 3.
    cycle(0, 1, 32'd60, 32'd3);
    cycle(0, 1, 32'd56, 32'h1);
    for (int k = 0; k < 5; k++) exp_q.push_back((k < 3) ? 32'd1 : 32'd0);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("pulse_pin",  32'(IO_port[16]),   e);
      check("pulse_busy", 32'(pulse_busy[1]), e);
      idle(1);
    end
    address = 32'd60; we = 1'b0;
    #1;
    check("plen_rd", rd_data, 32'd3);

    // Retrigger: length 4, second pulse two cycles after the first.
    cycle(0, 1, 32'd60, 32'd4);
    cycle(0, 1, 32'd56, 32'h1);
    idle(1);
    cycle(0, 1, 32'd56, 32'h2);
    for (int k = 0; k < 5; k++) begin
      check("retrig_pins", 32'(IO_port[17:16]), (k < 4) ? 32'd3 : 32'd0);
      idle(1);
    end

    // PLEN=0 makes PULSE a no-op; out-of-map writes are ignored.
    cycle(0, 1, 32'd60, 32'd0);
    cycle(0, 1, 32'd56, 32'h0000FFFF);
    check("plen0_pins", 32'(IO_port[31:16]), 32'd0);
    check("plen0_busy", 32'(pulse_busy), 32'd0);
    cycle(0, 1, 32'd4, 32'hFFFFFFFF);
    cycle(0, 1, 32'd200, 32'hFFFFFFFF);
    check("miss_io", IO_port, 32'h0000FF30);

    // Reset while a pulse is running.
    cycle(0, 1, 32'd8, 32'h00001234);
    cycle(0, 1, 32'd28, 32'd5);
    cycle(0, 1, 32'd24, 32'h00008000);
    idle(1);
    cycle(1, 1, 32'd8, 32'h0000FFFF);
    check("rst_io", IO_port, 32'd0);
    check("rst_busy", 32'(pulse_busy), 32'd0);
    address = 32'd28; we = 1'b0;
    #1;
    check("rst_plen", rd_data, 32'd1);

    // Randomized traffic with short pulse lengths to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      a = addr_tab[$urandom_range(0, 18)];
      if (a == 32'd28 || a == 32'd60) d = $urandom_range(0, 5);
      else if ($urandom_range(0, 1) == 1) d = 32'(1 << $urandom_range(0, 3));
      else d = $urandom;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
